// File: rtl/palindrome_stream_detector.sv
`default_nettype none
// ============================================================================
// Module      : palindrome_stream_detector
// Description : Collects a frame of SYM_WIDTH-bit symbols into an internal
//               buffer, then walks mirrored symbol pairs inward, one pair per
//               cycle, and reports whether the frame is a palindrome.
//               Frames longer than MAX_LEN symbols are flagged as overflowed
//               and are never reported as palindromes.
// Ports       : clk, reset         - clock, asynchronous active-high reset
//               din/din_valid/din_last/din_ready
//                                  - symbol input stream with frame marker
//               dout/dout_len/dout_overflow/dout_valid/dout_ready
//                                  - per-frame result handshake
// Revision    : 1.0 - initial release
// ============================================================================
module palindrome_stream_detector #(
    parameter int SYM_WIDTH = 8,
    parameter int MAX_LEN   = 16,
    localparam int LW       = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SYM_WIDTH-1:0] din,
    input  logic                 din_valid,
    input  logic                 din_last,
    output logic                 din_ready,
    output logic                 dout,
    output logic [LW-1:0]        dout_len,
    output logic                 dout_overflow,
    output logic                 dout_valid,
    input  logic                 dout_ready
);

    // Index width for the buffer and one extra bit for the lo/hi meet test,
    // so lo+1 and hi-1 can be compared without wrapping.
    localparam int IW  = $clog2(MAX_LEN);
    localparam int IW1 = IW + 1;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_CHECK   = 2'd1,
        S_RESULT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [LW-1:0]        cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [IW-1:0]        lo_q, lo_d;
    logic [IW-1:0]        hi_q, hi_d;
    logic                 dout_q, dout_d;
    logic [LW-1:0]        dout_len_q, dout_len_d;
    logic                 dout_overflow_q, dout_overflow_d;

    // Symbol buffer; contents are never reset because only indices below
    // the stored count are ever read.
    logic [SYM_WIDTH-1:0] mem [MAX_LEN];

    logic                 w_accept;
    logic                 w_cnt_full;
    logic                 w_wr_en;
    logic [IW1-1:0]       w_lo_inc;
    logic [IW1-1:0]       w_hi_dec;

    assign w_accept   = din_valid && (state_q == S_COLLECT);
    assign w_cnt_full = (cnt_q == LW'(MAX_LEN));
    assign w_lo_inc   = IW1'(lo_q) + IW1'(1);
    assign w_hi_dec   = IW1'(hi_q) - IW1'(1);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        ovf_d           = ovf_q;
        lo_d            = lo_q;
        hi_d            = hi_q;
        dout_d          = dout_q;
        dout_len_d      = dout_len_q;
        dout_overflow_d = dout_overflow_q;
        w_wr_en         = 1'b0;

        case (state_q)
            S_COLLECT: begin
                if (w_accept) begin
                    if (!w_cnt_full) begin
                        w_wr_en = 1'b1;
                        cnt_d   = cnt_q + LW'(1);
                    end else begin
                        // Buffer already holds MAX_LEN symbols: this one
                        // makes the frame too long.
                        ovf_d = 1'b1;
                    end
                    if (din_last) begin
                        state_d = S_CHECK;
                        lo_d    = '0;
                        // hi = stored_len - 1. When the last symbol is stored
                        // that equals the pre-increment count; otherwise the
                        // buffer is full and the overflow path resolves first.
                        hi_d    = w_cnt_full ? IW'(MAX_LEN - 1) : cnt_q[IW-1:0];
                    end
                end
            end

            S_CHECK: begin
                if (ovf_q) begin
                    state_d = S_RESULT;
                    dout_d  = 1'b0;
                end else if (lo_q >= hi_q) begin
                    // Only reachable on the first cycle for a 1-symbol frame.
                    state_d = S_RESULT;
                    dout_d  = 1'b1;
                end else if (mem[lo_q] != mem[hi_q]) begin
                    state_d = S_RESULT;
                    dout_d  = 1'b0;
                end else if (w_lo_inc >= w_hi_dec) begin
                    // Remaining inner span has at most one symbol left.
                    state_d = S_RESULT;
                    dout_d  = 1'b1;
                end else begin
                    lo_d = lo_q + IW'(1);
                    hi_d = hi_q - IW'(1);
                end

                if (state_d == S_RESULT) begin
                    dout_len_d      = cnt_q;
                    dout_overflow_d = ovf_q;
                end
            end

            S_RESULT: begin
                if (dout_ready) begin
                    state_d = S_COLLECT;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end

            default: begin
                state_d = S_COLLECT;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_COLLECT;
            cnt_q           <= '0;
            ovf_q           <= 1'b0;
            lo_q            <= '0;
            hi_q            <= '0;
            dout_q          <= 1'b0;
            dout_len_q      <= '0;
            dout_overflow_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            ovf_q           <= ovf_d;
            lo_q            <= lo_d;
            hi_q            <= hi_d;
            dout_q          <= dout_d;
            dout_len_q      <= dout_len_d;
            dout_overflow_q <= dout_overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem[cnt_q[IW-1:0]] <= din;
        end
    end

    // Handshake outputs decode from the registered state only.
    assign din_ready     = (state_q == S_COLLECT);
    assign dout_valid    = (state_q == S_RESULT);
    assign dout          = dout_q;
    assign dout_len      = dout_len_q;
    assign dout_overflow = dout_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_palindrome_stream_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_palindrome_stream_detector
// Description : Self-checking bench for palindrome_stream_detector. Frames
//               come from a vector table; expected results are queued when a
//               frame is sent and popped when the result appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_palindrome_stream_detector;

    localparam int SW = 8;
    localparam int ML = 16;
    localparam int LW = $clog2(ML + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] din;
    logic          din_valid;
    logic          din_last;
    logic          din_ready;
    logic          dout;
    logic [LW-1:0] dout_len;
    logic          dout_overflow;
    logic          dout_valid;
    logic          dout_ready;

    palindrome_stream_detector #(
        .SYM_WIDTH (SW),
        .MAX_LEN   (ML)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .din           (din),
        .din_valid     (din_valid),
        .din_last      (din_last),
        .din_ready     (din_ready),
        .dout          (dout),
        .dout_len      (dout_len),
        .dout_overflow (dout_overflow),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          d;
        logic [LW-1:0] len;
        logic          ovf;
        logic [7:0]    k;
    } exp_t;

    typedef struct packed {
        logic [16:0][7:0] sym;
        logic [7:0]       n;
        logic             gap;
        logic             d;
        logic [LW-1:0]    len;
        logic             ovf;
        logic [7:0]       k;
    } vec_t;

    vec_t vecs [9];
    exp_t sb [$];
    exp_t e;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [7:0] n, input logic g,
                           input logic d, input logic [LW-1:0] len,
                           input logic ovf, input logic [7:0] k,
                           input logic [16:0][7:0] s);
        vecs[i].sym = s;
        vecs[i].n   = n;
        vecs[i].gap = g;
        vecs[i].d   = d;
        vecs[i].len = len;
        vecs[i].ovf = ovf;
        vecs[i].k   = k;
    endtask

    // Drive one frame; returns right after the posedge that accepts the
    // last symbol. The expected result is queued up front.
    task automatic send_frame(input vec_t v);
        exp_t x;
        x.d   = v.d;
        x.len = v.len;
        x.ovf = v.ovf;
        x.k   = v.k;
        sb.push_back(x);
        for (int i = 0; i < 32'(v.n); i++) begin
            @(negedge clk);
            din       = v.sym[i];
            din_valid = 1'b1;
            din_last  = (i == 32'(v.n) - 1);
            chk("din_ready_collect", 32'(din_ready), 32'd1);
            @(posedge clk);
            if (v.gap && (i != 32'(v.n) - 1)) begin
                @(negedge clk);
                din_valid = 1'b0;
                din_last  = 1'b0;
            end
        end
    endtask

    // Wait for dout_valid, check latency and contents against the queue.
    // With hs=1 (dout_ready high) also check the return to COLLECT.
    task automatic wait_result(input logic hs, output exp_t r);
        int  lat  = 0;
        bit  seen = 1'b0;
        r = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            din_valid = 1'b0;
            din_last  = 1'b0;
            lat++;
            if (dout_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        r = sb.pop_front();
        if (!seen) begin
            chk("result_timeout", 32'd0, 32'd1);
            return;
        end
        chk("latency", 32'(lat), 32'(r.k) + 32'd1);
        chk("dout", 32'(dout), 32'(r.d));
        chk("dout_len", 32'(dout_len), 32'(r.len));
        chk("dout_overflow", 32'(dout_overflow), 32'(r.ovf));
        chk("din_ready_in_result", 32'(din_ready), 32'd0);
        if (hs) begin
            @(negedge clk);
            chk("din_ready_after_hs", 32'(din_ready), 32'd1);
            chk("dout_valid_after_hs", 32'(dout_valid), 32'd0);
        end
    endtask

    task automatic run_vec(input int i);
        exp_t r;
        send_frame(vecs[i]);
        wait_result(1'b1, r);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_din_ready"},     32'(din_ready),     32'd1);
        chk({tag, "_dout_valid"},    32'(dout_valid),    32'd0);
        chk({tag, "_dout"},          32'(dout),          32'd0);
        chk({tag, "_dout_len"},      32'(dout_len),      32'd0);
        chk({tag, "_dout_overflow"}, 32'(dout_overflow), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Vector table: symbols listed highest index first (rightmost = sym[0]).
        set_vec(0, 8'd5,  1'b0, 1'b1, 5'd5,  1'b0, 8'd2, {8'hA1, 8'hB2, 8'hC3, 8'hB2, 8'hA1});
        set_vec(1, 8'd4,  1'b1, 1'b0, 5'd4,  1'b0, 8'd1, {8'h04, 8'h03, 8'h02, 8'h01});
        set_vec(2, 8'd4,  1'b0, 1'b1, 5'd4,  1'b0, 8'd2, {8'h11, 8'h22, 8'h22, 8'h11});
        set_vec(3, 8'd1,  1'b0, 1'b1, 5'd1,  1'b0, 8'd1, {8'h7F});
        set_vec(4, 8'd16, 1'b0, 1'b1, 5'd16, 1'b0, 8'd8, '0);
        set_vec(5, 8'd17, 1'b0, 1'b0, 5'd16, 1'b1, 8'd1, '0);
        set_vec(6, 8'd7,  1'b0, 1'b0, 5'd7,  1'b0, 8'd3, {8'h10, 8'h20, 8'h31, 8'h40, 8'h30, 8'h20, 8'h10});
        set_vec(7, 8'd2,  1'b0, 1'b0, 5'd2,  1'b0, 8'd1, {8'h5B, 8'h5A});
        set_vec(8, 8'd2,  1'b0, 1'b1, 5'd2,  1'b0, 8'd1, {8'h05, 8'h05});

        reset      = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        din_last   = 1'b0;
        dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("por");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(i);
        end

        // Back-pressure: result must hold and input must be refused.
        dout_ready = 1'b0;
        send_frame(vecs[0]);
        wait_result(1'b0, e);
        for (int c = 0; c < 5; c++) begin
            din       = 8'h99;
            din_valid = 1'b1;
            din_last  = 1'b1;
            @(negedge clk);
            chk("bp_dout_valid", 32'(dout_valid), 32'd1);
            chk("bp_din_ready", 32'(din_ready), 32'd0);
            chk("bp_dout", 32'(dout), 32'(e.d));
            chk("bp_dout_len", 32'(dout_len), 32'(e.len));
            chk("bp_dout_overflow", 32'(dout_overflow), 32'(e.ovf));
        end
        din_valid  = 1'b0;
        din_last   = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_din_ready", 32'(din_ready), 32'd1);
        chk("bp_release_dout_valid", 32'(dout_valid), 32'd0);
        run_vec(3);

        // Reset after 3 symbols of a frame, then a fresh frame.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            din       = 8'h33 + 8'(i);
            din_valid = 1'b1;
            din_last  = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        din_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk_reset_values("midframe_rst");
        @(negedge clk);
        reset = 1'b0;
        run_vec(8);

        // Asynchronous reset while a result is being held.
        dout_ready = 1'b0;
        send_frame(vecs[4]);
        wait_result(1'b0, e);
        #2 reset = 1'b1;
        #1;
        chk_reset_values("result_rst");
        @(negedge clk);
        reset      = 1'b0;
        dout_ready = 1'b1;
        run_vec(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/palindrome_stream_detector.md
# palindrome_stream_detector

Streaming, parametrised palindrome checker that runs on frames of multi-bit symbols instead of one fixed-width word. Symbols arrive over a valid/ready input with a `din_last` frame marker and are buffered in an internal array of depth MAX_LEN. A state machine compares mirrored symbol pairs after the frame ends and presents a per-frame result (palindrome flag, frame length, overflow) on a valid/ready output. It sits between a symbol source and a result consumer, and handles frames of any length from 1 to MAX_LEN.

## Interface
- SYM_WIDTH, 8: width of one symbol in bits; symbols are compared whole, with no bit reversal.
- MAX_LEN, 16: buffer depth, which is the maximum frame length in symbols; must be ≥ 2.
- LW (localparam): $clog2(MAX_LEN+1).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  SYM_WIDTH  input symbol.
- din_valid  input  1  din is valid this cycle.
- din_last  input  1  din is the final symbol of the frame; qualified by din_valid.
- din_ready  output  1  block accepts a symbol this cycle.
- dout  output  1  1 = frame is a palindrome.
- dout_len  output  LW  number of symbols stored for the frame, saturating at MAX_LEN.
- dout_overflow  output  1  frame exceeded MAX_LEN symbols.
- dout_valid  output  1  result is valid.
- dout_ready  input  1  consumer accepts the result.

## Operation
- **Symbol accept.** A symbol is accepted when din_valid && din_ready.
- **FSM states:** COLLECT, CHECK, RESULT. Reset state is COLLECT.
- **COLLECT:**
  - din_ready=1.
  - Each accepted symbol is written to mem[cnt], then cnt increments.
  - When cnt==MAX_LEN, further symbols are not stored, cnt holds, and the ovf flag sets.
  - An accepted symbol with din_last=1 moves the FSM to CHECK and loads lo=0, hi=stored_len-1. The last symbol itself is stored (subject to the overflow rule).
  - There is no empty frame: the last symbol always counts, so length ≥ 1.
- **CHECK:**
  - din_ready=0. One pair is compared per cycle: mem[lo] vs mem[hi].
  - If ovf is set: resolve in the first CHECK cycle with result=0.
  - Else if lo ≥ hi (length 1): resolve with result=1.
  - Else if mem[lo] != mem[hi]: resolve with result=0 (early exit).
  - Else if lo+1 ≥ hi-1: resolve with result=1.
  - Else: lo++, hi--, and stay in CHECK.
  - On resolve: register dout, dout_len, dout_overflow and go to RESULT.
- **RESULT:**
  - dout_valid=1 and din_ready=0.
  - dout, dout_len and dout_overflow hold stable until dout_valid && dout_ready.
  - On that handshake: clear cnt and ovf, go to COLLECT, and set dout_valid=0 the next cycle.
- **Idle input.** din_valid=0 cycles inside a frame are ignored; the frame continues.
- **Output contents.** dout_len = stored count, equal to min(frame length, MAX_LEN). dout_overflow=1 only when the frame had more than MAX_LEN symbols. Exactly MAX_LEN symbols is not an overflow.
- **Reset values** (any time, including mid-frame or mid-CHECK): state=COLLECT, cnt=0, ovf=0, dout=0, dout_len=0, dout_overflow=0, dout_valid=0, din_ready=1. Partial frames are discarded.
- **Memory.** Contents are not reset; only indices below cnt are ever read.

## Timing
- din_ready and dout_valid decode from the registered state only. There is no combinational path from din_valid or dout_ready.
- **CHECK duration** k for frame length L (non-overflow):
  - k = floor(L/2) cycles when all pairs match, except L=1 gives k=1.
  - On a mismatch at pair index p (0-based), k = p+1.
  - For an overflowed frame, k = 1.
- **Latency.** If the last symbol is accepted in cycle 0, CHECK spans cycles 1..k and dout_valid is high from cycle k+1.
- **Throughput.** If the result handshake happens in cycle r, din_ready=1 from cycle r+1. Per frame, the minimum is L + k + 1 cycles.
- **Back-pressure.** dout_ready may stay low indefinitely. The result holds and no input is accepted.

## Test plan
- **Reset.** Assert reset asynchronously mid-cycle → all outputs immediately take their reset values: din_ready=1, dout_valid=0, dout=0, dout_len=0, dout_overflow=0.
- **Odd palindrome.** With dout_ready=1, send 0xA1,0xB2,0xC3,0xB2,0xA1 with last on the fifth symbol → CHECK for 2 cycles; dout_valid=1 in cycle 3 after the last accept, with dout=1, dout_len=5, dout_overflow=0; din_ready=1 in cycle 4.
- **Early mismatch and idle gaps.**
  - Send 0x01,0x02,0x03,0x04 with din_valid=0 gaps between symbols → dout=0, dout_len=4, dout_valid in cycle 2 (k=1).
  - Then send the even palindrome 0x11,0x22,0x22,0x11 → dout=1, dout_len=4.
- **Single symbol.** Send 0x7F with last → dout=1, dout_len=1, dout_valid in cycle 2.
- **Boundaries.**
  - 16 symbols 0x00 → dout=1, dout_len=16, dout_overflow=0, k=8.
  - 17 symbols 0x00 → dout=0, dout_len=16, dout_overflow=1, dout_valid in cycle 2.
- **Back-pressure and reset.**
  - Hold dout_ready=0 for 5 cycles in RESULT while driving din_valid=1 → outputs stay stable and din_ready=0; the next frame starts only after the handshake.
  - Separately, assert reset after 3 symbols of a frame → reset values apply, and a fresh frame 0x05,0x05 gives dout=1, dout_len=2.
